// File: rtl/lb_sched_pkg.sv
// Shared definitions for the load-balancing task scheduler.
// Holds the FSM state encoding, the server count and index widths, and the
// default load threshold used by lb_task_scheduler and lb_req_arbiter.
package lb_sched_pkg;

  localparam int NUM_SERVERS   = 3;
  localparam int SRV_IDX_W     = 2;
  localparam int REQ_IDX_W     = 3;
  localparam int DEF_THRESHOLD = 3;

  // State encoding kept as plain constants so legacy netlists and waveform
  // decoders keep working; the enum below is built on the same values.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT,
    STALL = ST_STALL
  } sched_state_e;

endpackage

// File: rtl/lb_req_arbiter.sv
// Requester arbiter for lb_task_scheduler.
// Picks one of eight requesters and returns it both one-hot and as an index.
//   i_req      in   8  pending requests
//   i_rr_ptr   in   3  round-robin search start (absent in strict mode)
//   o_win_oh   out  8  one-hot winner, zero when no request
//   o_win_idx  out  3  winner index, zero when no request
// Macro LB_STRICT_PRIO_EN: when defined, the highest set request index wins
// (same ordering as the datapath priority encoder) and there is no pointer.
module lb_req_arbiter
  import lb_sched_pkg::*;
(
  input  logic [7:0]           i_req,
`ifndef LB_STRICT_PRIO_EN
  input  logic [REQ_IDX_W-1:0] i_rr_ptr,
`endif
  output logic [7:0]           o_win_oh,
  output logic [REQ_IDX_W-1:0] o_win_idx
);

`ifdef LB_STRICT_PRIO_EN
  // Ascending scan: the last hit, i.e. the highest index, is kept.
  always_comb begin
    o_win_idx = '0;
    for (int k = 0; k < 8; k++) begin
      if (i_req[k]) o_win_idx = REQ_IDX_W'(k);
    end
    o_win_oh            = '0;
    o_win_oh[o_win_idx] = |i_req;
  end
`else
  logic                 w_found;
  logic [REQ_IDX_W-1:0] w_cand;

  // Scan starting at the pointer; the 3-bit add wraps 7 -> 0 naturally.
  always_comb begin
    o_win_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int k = 0; k < 8; k++) begin
      w_cand = i_rr_ptr + REQ_IDX_W'(k);
      if (!w_found && i_req[w_cand]) begin
        w_found   = 1'b1;
        o_win_idx = w_cand;
      end
    end
    o_win_oh            = '0;
    o_win_oh[o_win_idx] = |i_req;
  end
`endif

endmodule

// File: rtl/lb_task_scheduler.sv
// Dispatch sequencer for the three-server load-balancing datapath.
// Grants one requester per dispatch, steers it to the least-loaded server,
// tracks outstanding load per server and stalls while all are overloaded.
//   clk       in   1        system clock, rising edge
//   reset     in   1        asynchronous, active-high
//   req       in   8        level requests, held until granted
//   grant     out  8        one-hot single-cycle grant
//   srv_sel   out  2        server for the current grant, 0 when no grant
//   srv_done  in   3        per-server completion pulses
//   srv_load  out  3*CNT_W  packed loads, server0 in the low bits
//   trigger   out  1        some server load above THRESHOLD
//   overload  out  1        every server load above THRESHOLD
//   busy      out  1        FSM not idle
// Macro LB_STRICT_PRIO_EN: fixed highest-index priority, no rr pointer.
//
// state | meaning
// IDLE  | waiting for a request
// GRANT | one-cycle dispatch: pick requester and server, pulse grant
// STALL | every server overloaded (or saturated); hold until one drains
module lb_task_scheduler
  import lb_sched_pkg::*;
#(
  parameter int NUM_REQ   = 8,
  parameter int CNT_W     = 4,
  parameter int THRESHOLD = DEF_THRESHOLD
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  output logic [NUM_REQ-1:0]           grant,
  output logic [SRV_IDX_W-1:0]         srv_sel,
  input  logic [NUM_SERVERS-1:0]       srv_done,
  output logic [NUM_SERVERS*CNT_W-1:0] srv_load,
  output logic                         trigger,
  output logic                         overload,
  output logic                         busy
);

  localparam logic [CNT_W-1:0] LOAD_MAX = '1;
  localparam logic [CNT_W-1:0] LOAD_THR = CNT_W'(THRESHOLD);

  sched_state_e         r_state;
  sched_state_e         w_state_nxt;
  logic [CNT_W-1:0]     r_load [NUM_SERVERS];
  logic [NUM_REQ-1:0]   w_win_oh;
  logic [REQ_IDX_W-1:0] w_win_idx;
  logic [NUM_SERVERS-1:0] w_over;
  logic                 w_srv_ok;
  logic [SRV_IDX_W-1:0] w_srv_idx;
  logic [CNT_W-1:0]     w_best;
  logic                 w_req_any;
  logic                 w_grant_go;

`ifndef LB_STRICT_PRIO_EN
  logic [REQ_IDX_W-1:0] r_rr_ptr;
`endif

  lb_req_arbiter u_arb (
    .i_req     (req),
`ifndef LB_STRICT_PRIO_EN
    .i_rr_ptr  (r_rr_ptr),
`endif
    .o_win_oh  (w_win_oh),
    .o_win_idx (w_win_idx)
  );

  assign w_req_any = |req;

  always_comb begin
    srv_load = '0;
    w_over   = '0;
    for (int s = 0; s < NUM_SERVERS; s++) begin
      srv_load[s*CNT_W +: CNT_W] = r_load[s];
      w_over[s]                  = r_load[s] > LOAD_THR;
    end
  end

  assign trigger  = |w_over;
  assign overload = &w_over;

  // Least-loaded server; strict '<' keeps the lowest index on ties.
  // Saturated servers are skipped so the counter can never wrap.
  always_comb begin
    w_srv_ok  = 1'b0;
    w_srv_idx = '0;
    w_best    = '0;
    for (int s = 0; s < NUM_SERVERS; s++) begin
      if (r_load[s] != LOAD_MAX && (!w_srv_ok || r_load[s] < w_best)) begin
        w_srv_ok  = 1'b1;
        w_srv_idx = SRV_IDX_W'(s);
        w_best    = r_load[s];
      end
    end
  end

  assign w_grant_go = (r_state == GRANT) && w_req_any && !overload && w_srv_ok;
  assign grant      = w_grant_go ? w_win_oh  : '0;
  assign srv_sel    = w_grant_go ? w_srv_idx : '0;
  assign busy       = (r_state != IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_req_any) w_state_nxt = overload ? STALL : GRANT;
      GRANT: begin
        if (!w_req_any)                 w_state_nxt = IDLE;
        else if (overload || !w_srv_ok) w_state_nxt = STALL;
        else                            w_state_nxt = IDLE;
      end
      STALL:   if (!overload) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

`ifndef LB_STRICT_PRIO_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_grant_go) begin
      r_rr_ptr <= w_win_idx + REQ_IDX_W'(1);
    end
  end
`endif

  // An assignment and a completion on the same server cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SERVERS; s++) r_load[s] <= '0;
    end else begin
      for (int s = 0; s < NUM_SERVERS; s++) begin
        if (w_grant_go && w_srv_idx == SRV_IDX_W'(s)) begin
          if (!srv_done[s] && r_load[s] != LOAD_MAX) r_load[s] <= r_load[s] + 1'b1;
        end else if (srv_done[s] && r_load[s] != '0) begin
          r_load[s] <= r_load[s] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lb_task_scheduler.sv
module tb_lb_task_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  req;
  logic [7:0]  grant;
  logic [1:0]  srv_sel;
  logic [2:0]  srv_done;
  logic [11:0] srv_load;
  logic        trigger;
  logic        overload;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lb_task_scheduler dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .grant    (grant),
    .srv_sel  (srv_sel),
    .srv_done (srv_done),
    .srv_load (srv_load),
    .trigger  (trigger),
    .overload (overload),
    .busy     (busy)
  );

  typedef struct {
    logic [7:0]  req;
    logic [2:0]  done;
    logic [7:0]  grant;
    logic [1:0]  sel;
    logic [11:0] load;
    logic        busy;
  } vec_t;

  vec_t tbl [18];

  // Reference model state
  int m_phase;   // 0 waiting, 1 dispatching, 2 stalled
  int m_load [3];
  int m_rr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rr_or_strict(input logic [7:0] v);
`ifdef LB_STRICT_PRIO_EN
    return 8'h80;
`else
    return v;
`endif
  endfunction

  task automatic do_reset();
    reset    = 1'b1;
    req      = '0;
    srv_done = '0;
    @(posedge clk);
    #1;
    check("rst.grant", grant, 0);
    check("rst.sel", srv_sel, 0);
    check("rst.load", srv_load, 0);
    check("rst.trig", trigger, 0);
    check("rst.ovl", overload, 0);
    check("rst.busy", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic int pick_server();
    int best;
    best = -1;
    for (int s = 0; s < 3; s++)
      if (m_load[s] < 15 && (best < 0 || m_load[s] < m_load[best])) best = s;
    return best;
  endfunction

  function automatic int pick_req(input logic [7:0] r);
`ifdef LB_STRICT_PRIO_EN
    for (int i = 7; i >= 0; i--) if (r[i]) return i;
`else
    for (int k = 0; k < 8; k++) if (r[(m_rr + k) % 8]) return (m_rr + k) % 8;
`endif
    return -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pending;
    int done_pct;

    tbl[0]  = '{8'h01, 3'b000, 8'h00, 2'd0, 12'h000, 1'b0};
    tbl[1]  = '{8'h01, 3'b000, 8'h01, 2'd0, 12'h000, 1'b1};
    tbl[2]  = '{8'h01, 3'b000, 8'h00, 2'd0, 12'h001, 1'b0};
    tbl[3]  = '{8'h01, 3'b000, 8'h01, 2'd1, 12'h001, 1'b1};
    tbl[4]  = '{8'h01, 3'b000, 8'h00, 2'd0, 12'h011, 1'b0};
    tbl[5]  = '{8'h01, 3'b000, 8'h01, 2'd2, 12'h011, 1'b1};
    tbl[6]  = '{8'h00, 3'b000, 8'h00, 2'd0, 12'h111, 1'b0};
    tbl[7]  = '{8'hFF, 3'b000, 8'h00, 2'd0, 12'h111, 1'b0};
    tbl[8]  = '{8'hFF, 3'b000, rr_or_strict(8'h02), 2'd0, 12'h111, 1'b1};
    tbl[9]  = '{8'hFF, 3'b000, 8'h00, 2'd0, 12'h112, 1'b0};
    tbl[10] = '{8'hFF, 3'b000, rr_or_strict(8'h04), 2'd1, 12'h112, 1'b1};
    tbl[11] = '{8'hFF, 3'b000, 8'h00, 2'd0, 12'h122, 1'b0};
    tbl[12] = '{8'hFF, 3'b000, rr_or_strict(8'h08), 2'd2, 12'h122, 1'b1};
    tbl[13] = '{8'hFF, 3'b001, 8'h00, 2'd0, 12'h222, 1'b0};
    tbl[14] = '{8'hFF, 3'b001, rr_or_strict(8'h10), 2'd0, 12'h221, 1'b1};
    tbl[15] = '{8'h00, 3'b000, 8'h00, 2'd0, 12'h221, 1'b0};
    tbl[16] = '{8'h00, 3'b110, 8'h00, 2'd0, 12'h221, 1'b0};
    tbl[17] = '{8'h00, 3'b000, 8'h00, 2'd0, 12'h111, 1'b0};

    // Table-driven sequence from reset
    do_reset();
    for (int i = 0; i < 18; i++) begin
      req      = tbl[i].req;
      srv_done = tbl[i].done;
      #1;
      check($sformatf("vec%0d.grant", i), grant, tbl[i].grant);
      check($sformatf("vec%0d.sel", i), srv_sel, tbl[i].sel);
      check($sformatf("vec%0d.load", i), srv_load, tbl[i].load);
      check($sformatf("vec%0d.trig", i), trigger, 0);
      check($sformatf("vec%0d.ovl", i), overload, 0);
      check($sformatf("vec%0d.busy", i), busy, tbl[i].busy);
      @(posedge clk);
      #1;
    end

    // Round-robin order, 2-cycle spacing, then overload stall and release
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 12; k++) begin
      #1;
      check("rr.idle_grant", grant, 0);
      check("rr.idle_busy", busy, 0);
      step();
      #1;
      check($sformatf("rr%0d.grant", k), grant, rr_or_strict(8'(1 << (k % 8))));
      check($sformatf("rr%0d.sel", k), srv_sel, k % 3);
      step();
    end
    #1;
    check("ovl.load", srv_load, 12'h444);
    check("ovl.ovl", overload, 1);
    check("ovl.trig", trigger, 1);
    step();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall.busy", busy, 1);
      check("stall.grant", grant, 0);
      step();
    end
    srv_done = 3'b010;
    #1;
    check("stall_done.grant", grant, 0);
    step();
    srv_done = 3'b000;
    #1;
    check("drain.load", srv_load, 12'h434);
    check("drain.ovl", overload, 0);
    check("drain.trig", trigger, 1);
    check("drain.busy", busy, 1);
    step();
    #1;
    check("resume.idle_busy", busy, 0);
    step();
    #1;
    check("resume.grant", grant, rr_or_strict(8'h10));
    check("resume.sel", srv_sel, 1);
    step();
    #1;
    check("resume.load", srv_load, 12'h444);
    req = 8'h00;

    // Same-cycle assign/done cancels; done on empty server ignored
    do_reset();
    req = 8'h01;
    step();
    srv_done = 3'b001;
    #1;
    check("cancel.grant", grant, 8'h01);
    check("cancel.sel", srv_sel, 0);
    step();
    req      = 8'h00;
    srv_done = 3'b000;
    #1;
    check("cancel.load", srv_load, 12'h000);
    srv_done = 3'b100;
    step();
    srv_done = 3'b000;
    #1;
    check("underflow.load", srv_load, 12'h000);

    // Async reset in the middle of a dispatch
    do_reset();
    req = 8'h10;
    step();
    #1;
    check("midrst.pre_grant", grant, 8'h10);
    check("midrst.pre_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst.grant", grant, 0);
    check("midrst.busy", busy, 0);
    check("midrst.load", srv_load, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst.post_load", srv_load, 0);
    check("midrst.post_busy", busy, 0);
    req = 8'h00;

`ifdef LB_STRICT_PRIO_EN
    do_reset();
    req = 8'h81;
    for (int k = 0; k < 4; k++) begin
      step();
      #1;
      check("strict.grant", grant, 8'h80);
      step();
    end
    req = 8'h00;
`endif

    // Randomized run against the reference model
    do_reset();
    m_phase  = 0;
    m_rr     = 0;
    for (int s = 0; s < 3; s++) m_load[s] = 0;
    pending  = '0;
    done_pct = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int  srv, win, nphase;
      bit  ovl, trg, go;
      logic [7:0]  eg;
      logic [1:0]  es;
      logic [11:0] el;
      if (cyc % 300 == 0) done_pct = $urandom_range(0, 60);
      for (int i = 0; i < 8; i++) if ($urandom_range(0, 99) < 20) pending[i] = 1'b1;
      if ($urandom_range(0, 99) < 3) pending[$urandom_range(0, 7)] = 1'b0;
      req = pending;
      for (int s = 0; s < 3; s++) srv_done[s] = ($urandom_range(0, 99) < done_pct);
      #1;
      ovl = (m_load[0] > 3) && (m_load[1] > 3) && (m_load[2] > 3);
      trg = (m_load[0] > 3) || (m_load[1] > 3) || (m_load[2] > 3);
      srv = pick_server();
      win = pick_req(req);
      go  = (m_phase == 1) && (req != 0) && !ovl && (srv >= 0);
      eg  = go ? 8'(1 << win) : 8'h00;
      es  = go ? 2'(srv) : 2'd0;
      el  = 12'(m_load[0] + (m_load[1] << 4) + (m_load[2] << 8));
      check("rnd.grant", grant, eg);
      check("rnd.sel", srv_sel, es);
      check("rnd.load", srv_load, el);
      check("rnd.trig", trigger, trg);
      check("rnd.ovl", overload, ovl);
      check("rnd.busy", busy, m_phase != 0);

      nphase = m_phase;
      case (m_phase)
        0: if (req != 0) nphase = ovl ? 2 : 1;
        1: nphase = (req != 0 && (ovl || srv < 0)) ? 2 : 0;
        default: if (!ovl) nphase = 0;
      endcase
      for (int s = 0; s < 3; s++) begin
        if (go && srv == s) begin
          if (!srv_done[s] && m_load[s] < 15) m_load[s]++;
        end else if (srv_done[s] && m_load[s] > 0) begin
          m_load[s]--;
        end
      end
      if (go) begin
        m_rr    = (win + 1) % 8;
        pending = pending & ~eg;
      end
      m_phase = nphase;
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
